combat_resolver: RTL

- Turn-based combat controller directly upstream of the two per-player `character` stat blocks.
- Accepts each player's move selection and computes the `damage` and `cost` for that move, using attacker speed, defender dodge and an internal LFSR.
- Strobes the defender's `update`/`en` inputs, then reads back defender health to detect a knockout or the turn limit and declare a winner.

---
 rtl/combat_resolver.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/combat_resolver.sv
// Turn-based combat controller: resolves moves, strobes the defender's
// character block, and declares the winner on knockout or turn limit.
module combat_resolver #(
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter logic [6:0] TURN_LIMIT   = 7'd99,
  parameter logic [2:0] SPECIAL_COST = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move,
  input  logic [2:0] p0_speed,
  input  logic [2:0] p1_speed,
  input  logic [2:0] p0_dodge,
  input  logic [2:0] p1_dodge,
  input  logic [8:0] p0_health,
  input  logic [8:0] p1_health,
  input  logic [4:0] p0_special,
  input  logic [4:0] p1_special,
  output logic       move_ready,
  output logic       turn,
  output logic [5:0] damage,
  output logic [2:0] cost,
  output logic       p0_update,
  output logic       p1_update,
  output logic       p0_en,
  output logic       p1_en,
  output logic       hit,
  output logic [6:0] turn_count,
  output logic [1:0] winner,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MOVE,
    RESOLVE,
    APPLY,
    SETTLE,
    CHECK,
    GAME_OVER
  } state_t;

  localparam logic [1:0] MV_BASIC   = 2'd0;
  localparam logic [1:0] MV_HEAVY   = 2'd1;
  localparam logic [1:0] MV_SPECIAL = 2'd2;
  localparam logic [1:0] MV_REST    = 2'd3;

  localparam logic [7:0] SEED0 =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t     state, state_nx;
  logic [7:0] lfsr;
  logic [1:0] mv_q, mv_nx;
  logic       turn_nx, hit_nx;
  logic [5:0] damage_nx;
  logic [2:0] cost_nx;
  logic [6:0] tc_nx, tc_inc;
  logic [1:0] winner_nx;

  logic [2:0] a_spd, d_dg;
  logic [4:0] a_sp;
  logic [8:0] d_hp;
  logic [3:0] r;
  logic       sp_ok, basic_hit, heavy_hit;
  logic [5:0] basic_dmg, heavy_dmg;
  logic [5:0] res_dmg;
  logic [2:0] res_cost;
  logic       res_hit;
  logic       apply_go;

  assign a_spd = turn ? p1_speed : p0_speed;
  assign d_dg  = turn ? p0_dodge : p1_dodge;
  assign a_sp  = turn ? p1_special : p0_special;
  assign d_hp  = turn ? p0_health : p1_health;
  assign r     = lfsr[3:0];

  assign sp_ok     = a_sp >= {2'b00, SPECIAL_COST};
  assign basic_dmg = 6'd4 + {3'b000, a_spd};
  assign heavy_dmg = 6'd8 + {2'b00, a_spd, 1'b0};
  assign basic_hit = r >= {1'b0, d_dg};
  // Doubled dodge is kept to 4 bits, so dodge 7 needs r >= 14.
  assign heavy_hit = r >= {d_dg, 1'b0};
  assign tc_inc    = turn_count + 7'd1;

  always_comb begin
    res_dmg  = '0;
    res_cost = '0;
    res_hit  = 1'b0;
    unique case (mv_q)
      MV_BASIC: begin
        res_dmg = basic_dmg;
        res_hit = basic_hit;
      end
      MV_HEAVY: begin
        res_dmg = heavy_dmg;
        res_hit = heavy_hit;
      end
      MV_SPECIAL: begin
        if (sp_ok) begin
          res_dmg  = 6'd30;
          res_cost = SPECIAL_COST;
          res_hit  = 1'b1;
        end else begin
          res_dmg = basic_dmg;
          res_hit = basic_hit;
        end
      end
      default: begin
        res_dmg  = '0;
        res_cost = '0;
        res_hit  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mv_nx     = mv_q;
    turn_nx   = turn;
    hit_nx    = hit;
    damage_nx = damage;
    cost_nx   = cost;
    tc_nx     = turn_count;
    winner_nx = winner;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_nx  = WAIT_MOVE;
          tc_nx     = '0;
          winner_nx = '0;
          hit_nx    = 1'b0;
          turn_nx   = p1_speed > p0_speed;
        end
      end
      WAIT_MOVE: begin
        if (move_valid) begin
          state_nx = RESOLVE;
          mv_nx    = move;
        end
      end
      RESOLVE: begin
        state_nx  = APPLY;
        hit_nx    = res_hit;
        cost_nx   = res_cost;
        damage_nx = res_hit ? res_dmg : 6'd0;
      end
      APPLY:  state_nx = SETTLE;
      SETTLE: state_nx = CHECK;
      CHECK: begin
        tc_nx = tc_inc;
        if (d_hp == 9'd0) begin
          state_nx  = GAME_OVER;
          winner_nx = turn ? 2'b10 : 2'b01;
        end else if (tc_inc == TURN_LIMIT) begin
          state_nx = GAME_OVER;
          if (p0_health > p1_health) begin
            winner_nx = 2'b01;
          end else if (p1_health > p0_health) begin
            winner_nx = 2'b10;
          end else begin
            winner_nx = 2'b11;
          end
        end else begin
          state_nx = WAIT_MOVE;
          turn_nx  = ~turn;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED0;
      mv_q       <= '0;
      turn       <= 1'b0;
      hit        <= 1'b0;
      damage     <= '0;
      cost       <= '0;
      turn_count <= '0;
      winner     <= '0;
    end else begin
      lfsr       <= {lfsr[6:0],
                     lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      mv_q       <= mv_nx;
      turn       <= turn_nx;
      hit        <= hit_nx;
      damage     <= damage_nx;
      cost       <= cost_nx;
      turn_count <= tc_nx;
      winner     <= winner_nx;
    end
  end

  // Only the defender is strobed; a reset cycle suppresses it.
  assign apply_go   = (state == APPLY) && (mv_q != MV_REST) && !rst;
  assign p0_update  = apply_go && turn;
  assign p1_update  = apply_go && !turn;
  assign p0_en      = apply_go && turn;
  assign p1_en      = apply_go && !turn;
  assign move_ready = state == WAIT_MOVE;
  assign done       = state == GAME_OVER;

endmodule
